// File: rtl/pwl_arb_pkg.sv
// Shared constants and state encoding for the PWL activation arbiter.
package pwl_arb_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 16;
   localparam int TAG_W_DEF   = $clog2(NUM_REQ_DEF);
   localparam int STATS_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting lane at or after ptr_i wins.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_vld_o
);

   logic [IDX_W-1:0] lane;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      lane      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         lane = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (!gnt_vld_o && req_i[lane]) begin
            gnt_o[lane] = 1'b1;
            gnt_idx_o   = lane;
            gnt_vld_o   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwl_act_arbiter.sv
// Shares one fixed-latency PWL activation unit between NUM_REQ lanes with a tag pipe.
// Optional per-lane grant counters are enabled by defining PWL_ARB_STATS_EN.
module pwl_act_arbiter
   import pwl_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PWL_LAT = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_en,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_x,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        pwl_valid_in,
   output logic signed [DATA_W-1:0]    pwl_x,
   input  logic                        pwl_valid_out,
   input  logic signed [DATA_W-1:0]    pwl_y,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic signed [DATA_W-1:0]    rsp_y,
   output logic                        busy,
   output logic                        err
`ifdef PWL_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STATS_W-1:0]  grant_cnt
`endif
);

   localparam int TAG_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(PWL_LAT + 2);

   arb_state_e                state_q, state_d;
   logic [TAG_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      err_q, err_d;
   logic                      pwl_vld_q;
   logic signed [DATA_W-1:0]  pwl_x_q, sel_x;
   logic [NUM_REQ-1:0]        rsp_vld_q, rsp_vld_d;
   logic signed [DATA_W-1:0]  rsp_y_q;

   // Stage 0 is aligned with pwl_valid_in; stage PWL_LAT with pwl_valid_out.
   logic                      tag_vld_q [PWL_LAT+1];
   logic [TAG_W-1:0]          tag_idx_q [PWL_LAT+1];

   logic [NUM_REQ-1:0]        gnt;
   logic [TAG_W-1:0]          gnt_idx;
   logic                      gnt_vld;
   logic                      grant_en, accept, exit_vld, fire;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (TAG_W)
   ) u_rr (
      .req_i     (req_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   assign grant_en  = (state_q == ST_RUN);
   assign req_ready = grant_en ? gnt : '0;
   assign accept    = grant_en & gnt_vld;
   assign exit_vld  = tag_vld_q[PWL_LAT];
   assign fire      = exit_vld & pwl_valid_out;

   always_comb begin
      sel_x = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) sel_x = req_x[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
      end
      cnt_d     = cnt_q + CNT_W'(accept) - CNT_W'(exit_vld);
      err_d     = err_q | (pwl_valid_out ^ exit_vld);
      rsp_vld_d = '0;
      if (fire) rsp_vld_d[tag_idx_q[PWL_LAT]] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cfg_en) state_d = ST_RUN;
         ST_RUN:   if (!cfg_en) state_d = (cnt_d != '0) ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: begin
            if (cfg_en)              state_d = ST_RUN;
            else if (cnt_d == '0)    state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         pwl_vld_q <= 1'b0;
         pwl_x_q   <= '0;
         rsp_vld_q <= '0;
         rsp_y_q   <= '0;
         for (int s = 0; s <= PWL_LAT; s++) begin
            tag_vld_q[s] <= 1'b0;
            tag_idx_q[s] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         pwl_vld_q    <= accept;
         if (accept) pwl_x_q <= sel_x;
         rsp_vld_q    <= rsp_vld_d;
         if (fire) rsp_y_q <= pwl_y;
         tag_vld_q[0] <= accept;
         tag_idx_q[0] <= gnt_idx;
         for (int s = 1; s <= PWL_LAT; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_idx_q[s] <= tag_idx_q[s-1];
         end
      end
   end

   assign pwl_valid_in = pwl_vld_q;
   assign pwl_x        = pwl_x_q;
   assign rsp_valid    = rsp_vld_q;
   assign rsp_y        = rsp_y_q;
   assign busy         = (state_q != ST_IDLE);
   assign err          = err_q;

`ifdef PWL_ARB_STATS_EN
   logic [STATS_W-1:0] gcnt_q [NUM_REQ];

   // Counters saturate so long runs never wrap back to small values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && gnt[i] && (gcnt_q[i] != '1)) gcnt_q[i] <= gcnt_q[i] + STATS_W'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign grant_cnt[g*STATS_W +: STATS_W] = gcnt_q[g];
   end
`endif

endmodule
